mac_frame_ctrl: RTL
===================

# mac_frame_ctrl

Parametrised serial MAC framing controller, the next-generation replacement for the 8-bit `mac_controller`. It serialises parallel words onto `mac_tx` at one bit per clock, framed as start bit, data LSB-first, optional even parity, then stop bit. It deserialises `mac_rx` independently and reports parity and framing errors. A `loopback` mode feeds the transmitter straight into the receiver for self-test.

## Interface
- `DATA_W`, default 8: data bits per frame, valid range 4..32.
- `PARITY_EN`, default 1: 1 inserts and checks even parity after the data bits; 0 omits it.
- `clk  in  1`: single clock; every register is updated on its rising edge.
- `reset_n  in  1`: reset, synchronous and active-low.
- `tx_data  in  DATA_W`: word to transmit; captured on accept.
- `tx_valid  in  1`: transmit request.
- `tx_ready  out  1`: transmitter idle; the accept condition is `tx_valid && tx_ready` at a clock edge.
- `tx_done  out  1`: one-cycle pulse while the stop bit is on `mac_tx`.
- `mac_tx  out  1`: serial line out; idles high.
- `mac_rx  in  1`: serial line in; idles high.
- `loopback  in  1`: 1 makes the RX path sample the internal `mac_tx` and ignore `mac_rx`.
- `rx_data  out  DATA_W`: last received word; held until the next frame completes.
- `rx_valid  out  1`: one-cycle pulse when a frame completes.
- `rx_parity_err  out  1`: parity mismatch for the current `rx_valid` frame; valid only with `rx_valid`.
- `rx_frame_err  out  1`: stop bit sampled 0; valid only with `rx_valid`.

## Operation
- Frame length F = DATA_W + 2 + PARITY_EN bits; one bit per clock.
- Parity bit = XOR of the data bits (even parity).
- TX FSM states and transitions:
  - IDLE → START on accept.
  - START → DATA.
  - DATA (bit counter 0..DATA_W-1) → PARITY if PARITY_EN, else STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- TX outputs: `tx_ready`=1 only in IDLE; `mac_tx` is registered.
- RX input stage: one sync flop `rx_s` samples `loopback ? mac_tx : mac_rx`.
- RX FSM states and transitions:
  - IDLE → DATA when `rx_s`=0.
  - DATA → PARITY or STOP, as for TX.
  - STOP samples the stop bit, pulses `rx_valid`, then goes to IDLE if the stop bit is 1, else to BREAK.
  - BREAK waits for `rx_s`=1, then goes to IDLE. A held-low line therefore never produces repeated frames.
- TX and RX run independently; full duplex when `loopback`=0.
- `loopback` is changed only while both FSMs are idle. Changing it mid-frame may corrupt that frame but must never hang the FSMs.

## Timing
- Reset values, while `reset_n`=0 and one cycle after: `mac_tx`=1, `tx_ready`=0, `tx_done`=0, `rx_valid`=0, `rx_parity_err`=0, `rx_frame_err`=0, `rx_data`=0, both FSMs in IDLE.
- `tx_ready` goes to 1 in the first cycle after `reset_n` rises.
- Accept at edge E0. The line carries bit j (j=0 is the start bit) during the cycle after edge E0+j, for j = 0..F-1.
- `tx_done`=1 during the cycle after edge E0+F-1. `tx_ready` returns to 1 after edge E0+F.
- Minimum inter-frame gap is one idle-high cycle, since the next start bit follows edge E0+F+1 at the earliest.
- RX consumes line bit j at edge E0+j+2. `rx_valid` and the error flags are high during the cycle after edge E0+F+1. Loopback latency is therefore F+1 edges from accept.
- `tx_valid` while `tx_ready`=0 is ignored; there is no queuing.
- Reset mid-frame aborts both FSMs immediately. The partial frame produces no `rx_valid` and no `tx_done`.

## Structure
- Package `mac_pkg` holds:
  - `tx_state_t`: IDLE, START, DATA, PARITY, STOP.
  - `rx_state_t`: IDLE, DATA, PARITY, STOP, BREAK.
  - A `frame_len(DATA_W, PARITY_EN)` function.
- Sub-module `mac_rx_deser`: sync flop, RX FSM, shift register and checks.
- The top level holds the TX FSM, the loopback mux and the instance of `mac_rx_deser`.

## Test plan
- Loopback, DATA_W=8, PARITY_EN=1, send 8'hA5 → `mac_tx` carries 0,1,0,1,0,0,1,0,1,0,1 after edges E0..E0+10; `tx_done` after edge E0+10; `rx_valid` with `rx_data`=8'hA5, both errors 0, after edge E0+12.
- Loopback, send 8'h07 → parity bit 1 on the line; received 8'h07 with no errors.
- Back-to-back 8'hA5 then 8'h3C with `tx_valid` held high → second start bit after edge E0+12; two clean `rx_valid` pulses exactly 12 cycles apart.
- External `mac_rx`, drive the 8'h3C frame with the parity bit flipped to 1 → `rx_data`=8'h3C, `rx_parity_err`=1, `rx_frame_err`=0. Then drive the stop bit as 0 and hold the line low for 20 cycles → one `rx_valid` with `rx_frame_err`=1, no further pulses until the line returns high.
- DATA_W=16, PARITY_EN=0, send 16'hBEEF in loopback → F=18; `rx_valid` after edge E0+19 with 16'hBEEF.
- Assert `reset_n`=0 at edge E0+5 mid-frame → `mac_tx`=1 and no `rx_valid` or `tx_done`; a new 8'h5A frame after release is received cleanly.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the serial MAC framing controller.
// State encodings for the TX and RX framers plus frame length arithmetic.
package mac_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic int frame_len(input int data_w, input int parity_en);
        return data_w + 2 + parity_en;
    endfunction

endpackage

// File: rtl/mac_rx_deser.sv
// Serial frame deserialiser: input sync flop, RX FSM, shift register,
// parity and stop-bit checks.
module mac_rx_deser
    import mac_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              line,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_parity_err,
    output logic              rx_frame_err
);

    localparam int CW = $clog2(DATA_W);

    rx_state_t         state;
    logic              rx_s;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              pbit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= RX_IDLE;
            rx_s          <= 1'b1;
            cnt           <= '0;
            shreg         <= '0;
            pbit          <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_s          <= line;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state <= RX_DATA;
                        cnt   <= '0;
                    end
                end
                RX_DATA: begin
                    shreg <= {rx_s, shreg[DATA_W-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1))
                        state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: begin
                    pbit  <= rx_s;
                    state <= RX_STOP;
                end
                RX_STOP: begin
                    rx_valid      <= 1'b1;
                    rx_data       <= shreg;
                    rx_parity_err <= (PARITY_EN != 0) && ((^shreg) != pbit);
                    rx_frame_err  <= !rx_s;
                    // A low stop bit means a held-low line; wait for it to release
                    state         <= rx_s ? RX_IDLE : RX_BREAK;
                end
                RX_BREAK: begin
                    if (rx_s)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mac_frame_ctrl.sv
// Serial MAC framing controller: TX framer, loopback mux and RX deserialiser.
// Frames are start bit, data LSB-first, optional even parity, stop bit.
module mac_frame_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              mac_tx,
    input  logic              mac_rx,
    input  logic              loopback,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_parity_err,
    output logic              rx_frame_err
);

    localparam int CW = $clog2(DATA_W);

    tx_state_t         state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              par;
    logic              rx_line;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            mac_tx   <= 1'b1;
            tx_ready <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state    <= TX_START;
                        tx_ready <= 1'b0;
                        mac_tx   <= 1'b0;
                        shreg    <= tx_data;
                        par      <= ^tx_data;
                    end else begin
                        tx_ready <= 1'b1;
                        mac_tx   <= 1'b1;
                    end
                end
                TX_START: begin
                    mac_tx <= shreg[0];
                    shreg  <= shreg >> 1;
                    cnt    <= '0;
                    state  <= TX_DATA;
                end
                TX_DATA: begin
                    // Bit 0 left in START, so the last data bit is out when cnt wraps
                    if (cnt == CW'(DATA_W - 1)) begin
                        if (PARITY_EN != 0) begin
                            mac_tx <= par;
                            state  <= TX_PARITY;
                        end else begin
                            mac_tx  <= 1'b1;
                            tx_done <= 1'b1;
                            state   <= TX_STOP;
                        end
                    end else begin
                        mac_tx <= shreg[0];
                        shreg  <= shreg >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    mac_tx  <= 1'b1;
                    tx_done <= 1'b1;
                    state   <= TX_STOP;
                end
                TX_STOP: begin
                    tx_ready <= 1'b1;
                    state    <= TX_IDLE;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    assign rx_line = loopback ? mac_tx : mac_rx;

    mac_rx_deser #(
        .DATA_W   (DATA_W),
        .PARITY_EN(PARITY_EN)
    ) u_rx (
        .clk          (clk),
        .reset_n      (reset_n),
        .line         (rx_line),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err)
    );

endmodule
